// File: rtl/bus_fifo_slave.sv
// Bus slave exposing a 32-bit FIFO through DATA/STATUS/CTRL/THRESH registers.
// Define FIFO_SLAVE_IRQ_EN to build the threshold interrupt (THRESH, CTRL.irq_en, irq).
module bus_fifo_slave #(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        s_sel,
   input  logic        s_wr,
   input  logic [7:0]  s_address,
   input  logic [31:0] s_din,
   output logic [31:0] s_dout,
   output logic        irq
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_ovf;
   logic          r_udf;
   logic [31:0]   r_dout;
   logic          r_irq_en;
   logic [CW-1:0] r_thresh;

   logic [2:0]    w_off;
   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_wr_status;
   logic          w_wr_ctrl;
   logic          w_wr_thresh;
   logic [31:0]   w_status;
   logic [31:0]   w_rdata;
   logic          w_unused_addr;

   assign w_off         = s_address[2:0];
   assign w_unused_addr = &s_address[7:3];
   assign w_empty       = (r_count == '0);
   assign w_full        = (r_count == FULL_CNT);
   assign w_push        = s_sel &&  s_wr && (w_off == 3'd0);
   assign w_pop         = s_sel && !s_wr && (w_off == 3'd0);
   assign w_wr_status   = s_sel &&  s_wr && (w_off == 3'd1);
   assign w_wr_ctrl     = s_sel &&  s_wr && (w_off == 3'd2);
   assign w_wr_thresh   = s_sel &&  s_wr && (w_off == 3'd3);

   always_comb begin
      w_status         = '0;
      w_status[0]      = w_empty;
      w_status[1]      = w_full;
      w_status[2]      = r_ovf;
      w_status[3]      = r_udf;
      w_status[8 +: CW] = r_count;
   end

   // Read mux reflects pre-access state; a pop on empty returns 0.
   always_comb begin
      w_rdata = '0;
      case (w_off)
         3'd0:    w_rdata = w_empty ? 32'd0 : r_mem[r_rd_ptr];
         3'd1:    w_rdata = w_status;
         3'd2:    w_rdata[0] = r_irq_en;
         3'd3:    w_rdata[CW-1:0] = r_thresh;
         default: w_rdata = '0;
      endcase
   end

   // Storage is not reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (w_push && !w_full)
         r_mem[r_wr_ptr] <= s_din;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
         r_dout   <= '0;
      end else begin
         r_dout <= (s_sel && !s_wr) ? w_rdata : 32'd0;
         if (w_push) begin
            if (w_full) begin
               r_ovf <= 1'b1;
            end else begin
               r_wr_ptr <= r_wr_ptr + AW'(1);
               r_count  <= r_count + CW'(1);
            end
         end
         if (w_pop) begin
            if (w_empty) begin
               r_udf <= 1'b1;
            end else begin
               r_rd_ptr <= r_rd_ptr + AW'(1);
               r_count  <= r_count - CW'(1);
            end
         end
         if (w_wr_status) begin
            if (s_din[2]) r_ovf <= 1'b0;
            if (s_din[3]) r_udf <= 1'b0;
         end
         if (w_wr_ctrl && s_din[1]) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end
      end
   end

`ifdef FIFO_SLAVE_IRQ_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_en <= 1'b0;
         r_thresh <= '0;
      end else begin
         if (w_wr_ctrl)   r_irq_en <= s_din[0];
         if (w_wr_thresh) r_thresh <= s_din[CW-1:0];
      end
   end

   assign irq = r_irq_en && (r_thresh != '0) && (r_count >= r_thresh);
`else
   logic w_unused_thresh_wr;

   assign r_irq_en           = 1'b0;
   assign r_thresh           = '0;
   assign w_unused_thresh_wr = w_wr_thresh;
   assign irq                = 1'b0;
`endif

   assign s_dout = r_dout;

endmodule

// File: tb/tb_bus_fifo_slave.sv
// Directed self-checking bench for bus_fifo_slave (default DEPTH=16).
module tb_bus_fifo_slave;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        s_sel = 1'b0;
   logic        s_wr = 1'b0;
   logic [7:0]  s_address = 8'd0;
   logic [31:0] s_din = 32'd0;
   logic [31:0] s_dout;
   logic        irq;

   int total = 0;
   int bad   = 0;

   bus_fifo_slave dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .s_sel     (s_sel),
      .s_wr      (s_wr),
      .s_address (s_address),
      .s_din     (s_din),
      .s_dout    (s_dout),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One-cycle write; called right after a falling edge.
   task automatic bus_wr(input logic [2:0] off, input logic [31:0] d);
      s_sel = 1'b1; s_wr = 1'b1; s_address = {5'd0, off}; s_din = d;
      @(negedge clk);
      s_sel = 1'b0; s_wr = 1'b0;
   endtask

   // One-cycle read; returns s_dout as seen in the cycle after the access.
   task automatic bus_rd(input logic [2:0] off, output logic [31:0] d);
      s_sel = 1'b1; s_wr = 1'b0; s_address = {5'd0, off};
      @(negedge clk);
      d = s_dout;
      s_sel = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] d2;

      // Reset
      repeat (3) @(negedge clk);
      chk("rst_dout", s_dout, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      bus_rd(3'd1, d);
      chk("rst_status", d, 32'h0000_0001);

      // Two pushes, back-to-back pops
      bus_wr(3'd0, 32'h1111_1111);
      bus_wr(3'd0, 32'h2222_2222);
      bus_rd(3'd1, d);
      chk("st_cnt2", d, 32'h0000_0200);
      bus_rd(3'd0, d);
      bus_rd(3'd0, d2);
      chk("pop1", d, 32'h1111_1111);
      chk("pop2", d2, 32'h2222_2222);
      @(negedge clk);
      chk("idle_dout", s_dout, 32'd0);
      bus_rd(3'd1, d);
      chk("st_after_pops", d, 32'h0000_0001);

      // Fill and overflow
      for (int i = 0; i < 16; i++) bus_wr(3'd0, 32'hA000_0000 + i);
      bus_wr(3'd0, 32'hDEAD_BEEF);
      bus_rd(3'd1, d);
      chk("st_full_ovf", d, 32'h0000_1006);
      for (int i = 0; i < 16; i++) begin
         bus_rd(3'd0, d);
         chk($sformatf("fill_pop%0d", i), d, 32'hA000_0000 + i);
      end
      bus_rd(3'd1, d);
      chk("st_drained", d, 32'h0000_0005);
      bus_wr(3'd1, 32'h0000_0004);
      bus_rd(3'd1, d);
      chk("st_ovf_clr", d, 32'h0000_0001);

      // Underflow
      bus_rd(3'd0, d);
      chk("pop_empty", d, 32'd0);
      bus_rd(3'd1, d);
      chk("st_udf", d, 32'h0000_0009);
      bus_wr(3'd1, 32'h0000_0008);
      bus_rd(3'd1, d);
      chk("st_udf_clr", d, 32'h0000_0001);

      // Pointer wrap
      for (int i = 0; i < 10; i++) bus_wr(3'd0, 32'hB000_0000 + i);
      for (int i = 0; i < 10; i++) begin
         bus_rd(3'd0, d);
         chk($sformatf("wrapA_pop%0d", i), d, 32'hB000_0000 + i);
      end
      for (int i = 0; i < 12; i++) bus_wr(3'd0, 32'hC000_0000 + i);
      bus_rd(3'd1, d);
      chk("st_cnt12", d, 32'h0000_0C00);
      for (int i = 0; i < 12; i++) begin
         bus_rd(3'd0, d);
         chk($sformatf("wrapB_pop%0d", i), d, 32'hC000_0000 + i);
      end

      // Unmapped offsets
      bus_wr(3'd6, 32'hFFFF_FFFF);
      bus_rd(3'd5, d);
      chk("rd_off5", d, 32'd0);
      bus_rd(3'd1, d);
      chk("st_after_off6", d, 32'h0000_0001);

`ifdef FIFO_SLAVE_IRQ_EN
      bus_wr(3'd3, 32'h0000_0003);
      bus_wr(3'd2, 32'h0000_0001);
      bus_rd(3'd3, d);
      chk("thresh_rd", d, 32'h0000_0003);
      bus_wr(3'd0, 32'h0000_0001);
      bus_wr(3'd0, 32'h0000_0002);
      chk("irq_cnt2", {31'd0, irq}, 32'd0);
      bus_wr(3'd0, 32'h0000_0003);
      chk("irq_cnt3", {31'd0, irq}, 32'd1);
      bus_rd(3'd0, d);
      chk("irq_pop", {31'd0, irq}, 32'd0);
      bus_wr(3'd2, 32'h0000_0003);
      chk("irq_flush", {31'd0, irq}, 32'd0);
      bus_rd(3'd2, d);
      chk("ctrl_rd", d, 32'h0000_0001);
      bus_rd(3'd1, d);
      chk("st_flush", d, 32'h0000_0001);
`else
      bus_wr(3'd3, 32'h0000_0003);
      bus_wr(3'd2, 32'h0000_0001);
      bus_rd(3'd3, d);
      chk("thresh_rd0", d, 32'd0);
      bus_rd(3'd2, d);
      chk("ctrl_rd0", d, 32'd0);
      for (int i = 0; i < 3; i++) bus_wr(3'd0, 32'h0000_0010 + i);
      chk("irq_tied0", {31'd0, irq}, 32'd0);
      bus_rd(3'd1, d);
      chk("st_cnt3", d, 32'h0000_0300);
      bus_wr(3'd2, 32'h0000_0002);
      bus_rd(3'd1, d);
      chk("st_flush", d, 32'h0000_0001);
`endif

      // Reset in the middle of a burst
      bus_wr(3'd0, 32'h5555_5555);
      bus_rd(3'd1, d);
      s_sel = 1'b1; s_wr = 1'b1; s_address = 8'd0; s_din = 32'h6666_6666;
      #2 reset_n = 1'b0;
      #1 chk("midrst_dout", s_dout, 32'd0);
      @(negedge clk);
      s_sel = 1'b0; s_wr = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      bus_rd(3'd1, d);
      chk("midrst_status", d, 32'h0000_0001);
      chk("midrst_irq", {31'd0, irq}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
